// File: rtl/parity_calc.sv
// parity_calc
//   Registered parity generator for a WIDTH-bit data word. Every rising edge
//   it registers the parity bit and the ones-count of the presented word, and
//   maintains a running (even) parity across a frame of valid words.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset; all outputs forced to 0
//   stream     data word, sampled every rising edge
//   in_valid   qualifies stream for the frame accumulator only
//   clr        synchronous clear / start-of-frame for the accumulator
//   out        registered word parity (even, or odd when ODD_PARITY=1)
//   ones_cnt   registered number of 1 bits in stream
//   frame_par  registered even parity of all valid words since last clr
//
// Qualifier semantics: there is no ready/backpressure. in_valid marks a word
// as belonging to the current frame on the edge it is sampled; out and
// ones_cnt ignore in_valid and update every edge. clr in the same cycle as
// in_valid starts a new frame with that word; clr alone empties the frame.

module parity_calc #(
  parameter int WIDTH      = 10,
  parameter int ODD_PARITY = 0,
  parameter int CW         = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] stream,
  input  logic             in_valid,
  input  logic             clr,
  output logic             out,
  output logic [CW-1:0]    ones_cnt,
  output logic             frame_par
);

  logic          word_par;   // raw even parity of stream
  logic          out_d,   out_q;
  logic [CW-1:0] cnt_d,   cnt_q;
  logic          frame_d, frame_q;

  // Reduction/adder trees feeding the single register stage.
  always_comb begin
    word_par = ^stream;
    out_d    = word_par ^ (ODD_PARITY != 0);
    cnt_d    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d = cnt_d + CW'(stream[i]);
    end
  end

  // Frame accumulator: never inverted by ODD_PARITY, it is always the even
  // parity of the concatenated frame.
  always_comb begin
    frame_d = frame_q;
    if (clr) begin
      frame_d = in_valid ? word_par : 1'b0;
    end else if (in_valid) begin
      frame_d = frame_q ^ word_par;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= 1'b0;
      cnt_q   <= '0;
      frame_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
    end
  end

  assign out       = out_q;
  assign ones_cnt  = cnt_q;
  assign frame_par = frame_q;

endmodule

// File: tb/tb_parity_calc.sv
module tb_parity_calc;

  // Packed expectation/observation layout (MSB first):
  //   a: WIDTH=10 even {frame, cnt[3:0], out}
  //   b: WIDTH=10 odd  {frame, cnt[3:0], out}
  //   c: WIDTH=1  even {frame, cnt[0:0], out}
  //   d: WIDTH=32 even {frame, cnt[5:0], out}
  localparam int W = 23;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [9:0]  s10 = '0;
  logic [0:0]  s1  = '0;
  logic [31:0] s32 = '0;
  logic        in_valid = 1'b0;
  logic        clr = 1'b0;

  logic       out_a, fp_a; logic [3:0] cnt_a;
  logic       out_b, fp_b; logic [3:0] cnt_b;
  logic       out_c, fp_c; logic [0:0] cnt_c;
  logic       out_d, fp_d; logic [5:0] cnt_d;

  parity_calc #(.WIDTH(10), .ODD_PARITY(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .stream(s10), .in_valid(in_valid), .clr(clr),
    .out(out_a), .ones_cnt(cnt_a), .frame_par(fp_a));
  parity_calc #(.WIDTH(10), .ODD_PARITY(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .stream(s10), .in_valid(in_valid), .clr(clr),
    .out(out_b), .ones_cnt(cnt_b), .frame_par(fp_b));
  parity_calc #(.WIDTH(1), .ODD_PARITY(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .stream(s1), .in_valid(in_valid), .clr(clr),
    .out(out_c), .ones_cnt(cnt_c), .frame_par(fp_c));
  parity_calc #(.WIDTH(32), .ODD_PARITY(0)) dut_d (
    .clk(clk), .rst_n(rst_n), .stream(s32), .in_valid(in_valid), .clr(clr),
    .out(out_d), .ones_cnt(cnt_d), .frame_par(fp_d));

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  bit m_fa = 1'b0, m_fc = 1'b0, m_fd = 1'b0;  // model frame parities

  function automatic int ones(input logic [31:0] v, input int w);
    int n = 0;
    for (int i = 0; i < w; i++) n += v[i] ? 1 : 0;
    return n;
  endfunction

  // Frame rule: parity of the bits of all valid words since the last clr.
  function automatic bit frame_next(input bit cur, input int n, input bit v, input bit c);
    bit wp = 1'((n % 2) != 0);
    if (c) return v ? wp : 1'b0;
    if (v) return cur ^ wp;
    return cur;
  endfunction

  function automatic logic [W-1:0] observed();
    return {fp_a, cnt_a, out_a, fp_b, cnt_b, out_b,
            fp_c, cnt_c, out_c, fp_d, cnt_d, out_d};
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%06h expected=%06h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [9:0] a, input logic [0:0] c1, input logic [31:0] d,
                       input bit v, input bit c);
    int na, nc, nd;
    s10 = a; s1 = c1; s32 = d; in_valid = v; clr = c;
    na = ones({22'd0, a}, 10);
    nc = ones({31'd0, c1}, 1);
    nd = ones(d, 32);
    m_fa = frame_next(m_fa, na, v, c);
    m_fc = frame_next(m_fc, nc, v, c);
    m_fd = frame_next(m_fd, nd, v, c);
    exp_q.push_back({m_fa, 4'(na), 1'((na % 2) != 0),
                     m_fa, 4'(na), 1'((na % 2) == 0),
                     m_fc, 1'(nc), 1'((nc % 2) != 0),
                     m_fd, 6'(nd), 1'((nd % 2) != 0)});
  endtask

  task automatic tick(input string tag);
    logic [W-1:0] e;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=none expected=queued entry", tag);
    end else begin
      e = exp_q.pop_front();
      check(tag, observed(), e);
    end
  endtask

  task automatic model_reset();
    m_fa = 1'b0; m_fc = 1'b0; m_fd = 1'b0;
    exp_q.delete();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    // Reset held with all-ones stream: every output stays 0.
    s10 = 10'h3FF; s1 = 1'b1; s32 = 32'hFFFF_FFFF;
    #12;
    check("reset_hold", observed(), '0);

    @(negedge clk);
    rst_n = 1'b1;
    drive(10'h3FF, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    tick("reset_release_all_ones");

    // Incrementing sweep from 809 with random side inputs.
    for (int i = 0; i < 200; i++) begin
      drive(10'(809 + i), 1'($urandom), $urandom, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 7) == 0));
      tick("sweep");
    end

    // Zero and single-bit words (odd instance inverts).
    drive(10'h000, 1'b0, 32'h0, 1'b0, 1'b0);
    tick("zero_word");
    drive(10'h001, 1'b1, 32'h1, 1'b0, 1'b0);
    tick("one_bit_word");

    // Frame accumulation.
    drive(10'h001, 1'b1, 32'h1, 1'b1, 1'b1);
    tick("frame_start");
    drive(10'h003, 1'b0, 32'h3, 1'b1, 1'b0);
    tick("frame_valid_3");
    drive(10'h004, 1'b1, 32'h4, 1'b1, 1'b0);
    tick("frame_valid_4");
    drive(10'h001, 1'b1, 32'h1, 1'b0, 1'b0);
    tick("frame_hold_invalid");
    drive(10'h001, 1'b1, 32'h1, 1'b1, 1'b0);
    tick("frame_valid_1");
    drive(10'h2A5, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1);
    tick("frame_clr_no_valid");

    // Async reset mid-frame, between edges.
    drive(10'h007, 1'b1, 32'h7, 1'b1, 1'b1);
    tick("frame_before_reset");
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_mid_frame", observed(), '0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive(10'h001, 1'b1, 32'h1, 1'b1, 1'b0);
    tick("frame_after_reset_no_clr");

    // Width corners with all-ones words.
    drive(10'h3FF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
    tick("corner_all_ones");

    // Short random tail.
    for (int i = 0; i < 40; i++) begin
      drive(10'($urandom), 1'($urandom), $urandom, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) == 0));
      tick("random_tail");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/parity_calc.md
Name: parity_calc

Overview:
- Registered parity generator for a WIDTH-bit parallel data word.
- Every clock it produces the parity bit of the presented word and its ones-count.
- It also keeps a running parity across a frame of valid words, cleared by the upstream framer.
- Sits on the datapath ahead of link/serializer logic that appends or checks the parity bit.

Parameters:
- WIDTH, 10, data word width in bits; must be ≥1.
- ODD_PARITY, 0, 0 = even parity (out = XOR of bits); 1 = odd parity (out = inverted XOR).
- CW, $clog2(WIDTH+1), width of the ones-count output; derived, not to be overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- stream  input  WIDTH  data word, sampled every rising edge.
- in_valid  input  1  qualifies stream for the frame accumulator only.
- clr  input  1  synchronous clear/start of the frame accumulator.
- out  output  1  registered word parity of stream.
- ones_cnt  output  CW  registered number of 1 bits in stream.
- frame_par  output  1  registered running parity of all valid words since the last clr.

Behaviour:
- One clock domain. Reset is asynchronous and active-low.
  - While rst_n=0: out=0, ones_cnt=0, frame_par=0, regardless of ODD_PARITY.
  - Outputs take effect immediately on assertion; the first update is the first rising edge with rst_n=1.
- out:
  - Every rising edge, out <= (^stream) XOR ODD_PARITY.
  - Updates unconditionally and is not gated by in_valid.
  - Latency is exactly 1 cycle; stream change at edge N is reflected after edge N+1.
- ones_cnt:
  - Every rising edge, ones_cnt <= popcount(stream).
  - Unsigned; range 0..WIDTH, so it never overflows.
  - Same 1-cycle latency as out.
  - Relation: out == ones_cnt[0] XOR ODD_PARITY.
- frame_par, evaluated at each rising edge (wp = ^stream, raw even parity of the word):
  - clr=1, in_valid=1: frame_par <= wp. A new frame starts with this word.
  - clr=1, in_valid=0: frame_par <= 0.
  - clr=0, in_valid=1: frame_par <= frame_par XOR wp.
  - clr=0, in_valid=0: hold.
  - ODD_PARITY inversion is not applied to frame_par; it is always the even parity of the concatenated frame.
- X/Z on stream is not handled; inputs are assumed driven.
- Bit ordering is irrelevant; all bits are weighted equally.
- Fully synthesizable.
  - Parity and popcount are combinational reduction/adder trees feeding a single register stage.
  - No multicycle paths.
- Reset mid-operation: all three outputs go to 0 at once; the frame is lost, and the next frame needs no clr.

Test Plan:
- Reset: hold rst_n=0 with stream=10'h3FF → out=0, ones_cnt=0, frame_par=0. Release rst_n; after 1 edge → out=0 (10 ones), ones_cnt=10.
- Incrementing stream (even mode), stream=809 (1100101001b), then +1 each clock:
  - 809 → out=1, ones_cnt=5; 810 → out=1, ones_cnt=5; 811 → out=0, ones_cnt=6.
  - Each value checked one cycle later.
  - Sweep 200 values and compare against a reference XOR/popcount.
- Odd mode (ODD_PARITY=1): stream=0 → out=1, ones_cnt=0. stream=10'h001 → out=0.
- Frame accumulation:
  - clr=1 with in_valid=1, stream=10'h001 → frame_par=1.
  - Then valid 10'h003 → stays 1; valid 10'h004 → 0.
  - An invalid word 10'h001 → holds 0.
- clr without valid → frame_par=0. Async reset asserted mid-frame, between clock edges → all outputs 0 immediately.
- Corner widths (WIDTH=1 and WIDTH=32):
  - stream all ones → WIDTH=1 gives out=1, ones_cnt=1.
  - WIDTH=32 gives out=0, ones_cnt=32.
